axi4l_dpram_x32: RTL and testbench
==================================

Name: axi4l_dpram_x32

Overview:
- AXI4-Lite slave wrapping a 32-bit-wide, byte-addressable RAM of `size` bytes.
- Built as a simple dual-port RAM: one write port and one read port.
- The write channel (AW/W/B) and read channel (AR/R) run independently and can complete in the same cycle.
- Used as on-chip SoC memory on the AXI4-Lite fabric.

Parameters:
- size, 'h80, RAM size in bytes. Power of two, >= 8. Word count is size/4; word index is addr[$clog2(size)-1:2].

Ports:
- aclk  in  1  clock, all logic on the rising edge
- aresetn  in  1  reset, synchronous, active-low
- awvalid  in  1  write address valid
- awready  out  1  write address ready
- awaddr  in  32  write byte address
- awprot  in  3  protection; ignored
- wvalid  in  1  write data valid
- wready  out  1  write data ready
- wdata  in  32  write data
- wstrb  in  4  byte-lane write enables; bit i covers wdata[8i+7:8i]
- bvalid  out  1  write response valid
- bready  in  1  write response ready
- bresp  out  2  write response (OKAY=0, SLVERR=2)
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- araddr  in  32  read byte address
- arprot  in  3  protection; ignored
- rvalid  out  1  read data valid
- rready  in  1  read data ready
- rdata  out  32  read data
- rresp  out  2  read response

All of the AXI4-Lite ports above are carried in one axi4l_if interface port named axi. The clock is aclk. The reset is aresetn: synchronous, active-low.

Behaviour:
- Reset (aresetn=0 at a rising edge) clears:
  - the internal flags valid_write_address, valid_write_data and valid_read_address;
  - bvalid and rvalid.
- After reset, awready=wready=arready=1; bresp=rresp=OKAY; rdata=0.
- RAM contents are not cleared by reset.
- Write address:
  - awready = !valid_write_address (combinational from the register).
  - On an awvalid&&awready handshake, latch awaddr and set valid_write_address.
- Write data:
  - wready = !valid_write_data.
  - On a handshake, latch wdata/wstrb and set valid_write_data.
  - AW and W may arrive in either order or in the same cycle.
- Write commit:
  - Condition: valid_write_address && valid_write_data && !(bvalid && !bready).
  - Action: write each byte lane whose latched wstrb bit is 1 into word waddr[$clog2(size)-1:2].
  - Also set bvalid=1, bresp=OKAY, and clear both valid flags.
  - Minimum latency: AW+W handshake in cycle N, bvalid asserted in cycle N+2.
- bvalid stays asserted with a stable bresp until bready; it clears on the handshake unless a new commit happens in that same cycle.
- Back-pressure: while B is stalled, one further address and one further data beat may be accepted. awready/wready then drop until the stall clears.
- Read address:
  - arready = !valid_read_address.
  - A handshake latches araddr and sets valid_read_address.
- Read:
  - Condition: valid_read_address && !(rvalid && !rready).
  - Action: rdata <= mem[word]; rvalid=1; rresp=OKAY; clear valid_read_address.
  - AR handshake in cycle N gives rvalid in cycle N+2.
- rvalid, rdata and rresp stay stable while rvalid && !rready.
- Simultaneous read and write commit to the same word in one cycle: the read returns the old data (read-before-write).
- Address bits above $clog2(size)-1 are ignored, so addresses alias/wrap modulo size. awaddr[1:0] and araddr[1:0] are ignored.
- Outstanding-count invariants:
  - Write address outstanding = bvalid + !awready.
  - Write data outstanding = bvalid + !wready.
  - Read outstanding = rvalid + !arready.
- bvalid and rvalid are never asserted without a prior matching handshake.
- Reset mid-transaction drops latched requests and pending responses; the RAM keeps any already-committed writes.

Optional Feature:
- Macro AXI4L_DPRAM_SLVERR_EN.
- When defined, an address >= size on AW or AR gets an error response:
  - Writes: suppress the RAM write; bresp=SLVERR.
  - Reads: rdata=0; rresp=SLVERR.
  - Handshake timing is unchanged.
- When undefined, addresses alias as above and bresp/rresp are always OKAY.

Test Plan:
- Reset, then write awaddr=0x04, wdata=0xDEADBEEF, wstrb=4'hF, bready=1 -> bvalid for 1 cycle with bresp=OKAY. Then read araddr=0x04 -> rdata=0xDEADBEEF, rresp=OKAY, rvalid 2 cycles after the AR handshake.
- Byte strobes: word 0x10 holds 0x11223344; write wdata=0xAABBCCDD, wstrb=4'b0101 -> read back 0x11BB33DD.
- W beat one cycle before AW, then AW; hold bready=0 for 3 cycles -> bvalid and bresp stay stable. A second AW+W is accepted, then awready=wready=0 until bready. Exactly 2 B responses follow.
- Read with rready=0 for 4 cycles -> rvalid/rdata held. A second AR is accepted and arready drops. After rready, two responses arrive in order.
- Aliasing, macro undefined: write 0x80 with 0x12345678 -> a read at 0x00 returns 0x12345678, OKAY. With AXI4L_DPRAM_SLVERR_EN: bresp=SLVERR, word 0 unchanged, and a read at 0x80 gives rresp=SLVERR, rdata=0.
- Back-to-back traffic: 5 writes and 5 reads with random valid/ready gaps, plus aresetn pulsed low mid-burst -> bvalid=rvalid=0 the cycle after reset, and no responses for dropped requests.

Source files
------------

// File: rtl/axi4l_dpram_x32_if.sv
// AXI4-Lite signal bundle shared by the fabric master and the axi4l_dpram_x32 slave.
interface axi4l_if;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi4l_dpram_x32.sv
// AXI4-Lite slave over a simple dual-port 32-bit RAM; independent write and read channels.
// Define AXI4L_DPRAM_SLVERR_EN to answer out-of-range addresses with SLVERR instead of aliasing.
module axi4l_dpram_x32 #(
  parameter int unsigned size = 'h80
) (
  input logic    aclk,
  input logic    aresetn,
  axi4l_if.slave axi
);

  localparam int unsigned AddrW = $clog2(size);
  localparam int unsigned Words = size / 4;
  localparam int unsigned IdxW  = AddrW - 2;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  logic [31:0] mem_q [Words];

  logic            aw_valid_q, aw_valid_d;
  logic [IdxW-1:0] aw_idx_q, aw_idx_d;
  logic            aw_err_q, aw_err_d;
  logic            w_valid_q, w_valid_d;
  logic [31:0]     w_data_q, w_data_d;
  logic [3:0]      w_strb_q, w_strb_d;
  logic            bvalid_q, bvalid_d;
  logic [1:0]      bresp_q, bresp_d;
  logic            ar_valid_q, ar_valid_d;
  logic [IdxW-1:0] ar_idx_q, ar_idx_d;
  logic            ar_err_q, ar_err_d;
  logic            rvalid_q, rvalid_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [1:0]      rresp_q, rresp_d;

  logic aw_hs, w_hs, ar_hs;
  logic wr_commit, rd_fire, mem_we;
  logic aw_oor, ar_oor;

`ifdef AXI4L_DPRAM_SLVERR_EN
  assign aw_oor = |axi.awaddr[31:AddrW];
  assign ar_oor = |axi.araddr[31:AddrW];
`else
  assign aw_oor = 1'b0;
  assign ar_oor = 1'b0;
`endif

  // Protection, sub-word and (in the aliasing build) upper address bits carry no meaning here.
  logic unused_sig;
  assign unused_sig = ^{axi.awprot, axi.arprot, axi.awaddr[1:0], axi.araddr[1:0],
                        axi.awaddr[31:AddrW], axi.araddr[31:AddrW]};

  assign axi.awready = ~aw_valid_q;
  assign axi.wready  = ~w_valid_q;
  assign axi.arready = ~ar_valid_q;
  assign axi.bvalid  = bvalid_q;
  assign axi.bresp   = bresp_q;
  assign axi.rvalid  = rvalid_q;
  assign axi.rdata   = rdata_q;
  assign axi.rresp   = rresp_q;

  assign aw_hs     = axi.awvalid & ~aw_valid_q;
  assign w_hs      = axi.wvalid & ~w_valid_q;
  assign ar_hs     = axi.arvalid & ~ar_valid_q;
  assign wr_commit = aw_valid_q & w_valid_q & ~(bvalid_q & ~axi.bready);
  assign rd_fire   = ar_valid_q & ~(rvalid_q & ~axi.rready);
  // A commit landing on a reset edge is dropped along with the request.
  assign mem_we    = wr_commit & ~aw_err_q & aresetn;

  always_comb begin
    aw_valid_d = aw_valid_q;
    aw_idx_d   = aw_idx_q;
    aw_err_d   = aw_err_q;
    w_valid_d  = w_valid_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;

    // Handshake and commit on a channel are exclusive: ready is low while its flag is set.
    if (aw_hs) begin
      aw_valid_d = 1'b1;
      aw_idx_d   = axi.awaddr[AddrW-1:2];
      aw_err_d   = aw_oor;
    end else if (wr_commit) begin
      aw_valid_d = 1'b0;
    end

    if (w_hs) begin
      w_valid_d = 1'b1;
      w_data_d  = axi.wdata;
      w_strb_d  = axi.wstrb;
    end else if (wr_commit) begin
      w_valid_d = 1'b0;
    end

    if (wr_commit) begin
      bvalid_d = 1'b1;
      bresp_d  = aw_err_q ? RespSlvErr : RespOkay;
    end else if (axi.bready) begin
      bvalid_d = 1'b0;
    end
  end

  always_comb begin
    ar_valid_d = ar_valid_q;
    ar_idx_d   = ar_idx_q;
    ar_err_d   = ar_err_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;

    if (ar_hs) begin
      ar_valid_d = 1'b1;
      ar_idx_d   = axi.araddr[AddrW-1:2];
      ar_err_d   = ar_oor;
    end else if (rd_fire) begin
      ar_valid_d = 1'b0;
    end

    // mem_q is sampled before this edge's write lands, giving read-before-write.
    if (rd_fire) begin
      rvalid_d = 1'b1;
      rdata_d  = ar_err_q ? 32'h0 : mem_q[ar_idx_q];
      rresp_d  = ar_err_q ? RespSlvErr : RespOkay;
    end else if (axi.rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      aw_valid_q <= 1'b0;
      aw_idx_q   <= '0;
      aw_err_q   <= 1'b0;
      w_valid_q  <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RespOkay;
      ar_valid_q <= 1'b0;
      ar_idx_q   <= '0;
      ar_err_q   <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RespOkay;
    end else begin
      aw_valid_q <= aw_valid_d;
      aw_idx_q   <= aw_idx_d;
      aw_err_q   <= aw_err_d;
      w_valid_q  <= w_valid_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      ar_valid_q <= ar_valid_d;
      ar_idx_q   <= ar_idx_d;
      ar_err_q   <= ar_err_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_strb_q[b]) begin
          mem_q[aw_idx_q][8*b +: 8] <= w_data_q[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_axi4l_dpram_x32.sv
// Directed bench for axi4l_dpram_x32: timing, strobes, back-pressure, aliasing and reset.
module tb_axi4l_dpram_x32;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  axi4l_if axi ();

  axi4l_dpram_x32 dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .axi     (axi)
  );

  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h, expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int bdelay, output logic [1:0] resp);
    bit aw_done, w_done, aw_hs, w_hs, got;
    aw_done = 0; w_done = 0; got = 0; resp = 2'b11;
    axi.awaddr = addr; axi.awvalid = 1'b1;
    axi.wdata = data; axi.wstrb = strb; axi.wvalid = 1'b1;
    axi.bready = 1'b0;
    for (int i = 0; i < 20 && !(aw_done && w_done); i++) begin
      aw_hs = axi.awvalid && axi.awready;
      w_hs  = axi.wvalid && axi.wready;
      tick();
      if (aw_hs) begin aw_done = 1; axi.awvalid = 1'b0; end
      if (w_hs) begin w_done = 1; axi.wvalid = 1'b0; end
    end
    for (int i = 0; i < 20 && !got; i++) begin
      if (axi.bvalid) begin
        repeat (bdelay) tick();
        resp = axi.bresp;
        axi.bready = 1'b1;
        tick();
        axi.bready = 1'b0;
        got = 1;
      end else begin
        tick();
      end
    end
    check("b_seen", got, 1);
  endtask

  task automatic axi_read(input logic [31:0] addr, input int rdelay,
                          output logic [31:0] data, output logic [1:0] resp);
    bit done, got;
    done = 0; got = 0; data = 'x; resp = 2'b11;
    axi.araddr = addr; axi.arvalid = 1'b1; axi.rready = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      done = axi.arready;
      tick();
    end
    axi.arvalid = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (axi.rvalid) begin
        repeat (rdelay) tick();
        data = axi.rdata; resp = axi.rresp;
        axi.rready = 1'b1;
        tick();
        axi.rready = 1'b0;
        got = 1;
      end else begin
        tick();
      end
    end
    check("r_seen", got, 1);
  endtask

  logic [31:0] rd;
  logic [1:0]  rs;
  int          nb, nr;

  initial begin
    axi.awvalid = 0; axi.awaddr = 0; axi.awprot = 0;
    axi.wvalid = 0; axi.wdata = 0; axi.wstrb = 0; axi.bready = 0;
    axi.arvalid = 0; axi.araddr = 0; axi.arprot = 0; axi.rready = 0;
    repeat (2) tick();
    aresetn = 1'b1;
    check("rst_awready", axi.awready, 1);
    check("rst_wready", axi.wready, 1);
    check("rst_arready", axi.arready, 1);
    check("rst_bvalid", axi.bvalid, 0);
    check("rst_rvalid", axi.rvalid, 0);
    check("rst_bresp", axi.bresp, 0);
    check("rst_rresp", axi.rresp, 0);
    check("rst_rdata", axi.rdata, 0);

    // Basic write with exact cycle timing.
    axi.awaddr = 32'h04; axi.awvalid = 1; axi.wdata = 32'hDEADBEEF; axi.wstrb = 4'hF;
    axi.wvalid = 1; axi.bready = 1;
    tick();
    axi.awvalid = 0; axi.wvalid = 0;
    check("w1_n1_bvalid", axi.bvalid, 0);
    check("w1_n1_awready", axi.awready, 0);
    tick();
    check("w1_n2_bvalid", axi.bvalid, 1);
    check("w1_n2_bresp", axi.bresp, 0);
    tick();
    check("w1_n3_bvalid", axi.bvalid, 0);
    axi.bready = 0;

    // Basic read with exact cycle timing.
    axi.araddr = 32'h04; axi.arvalid = 1; axi.rready = 1;
    tick();
    axi.arvalid = 0;
    check("r1_n1_rvalid", axi.rvalid, 0);
    check("r1_n1_arready", axi.arready, 0);
    tick();
    check("r1_n2_rvalid", axi.rvalid, 1);
    check("r1_n2_rdata", axi.rdata, 32'hDEADBEEF);
    check("r1_n2_rresp", axi.rresp, 0);
    tick();
    check("r1_n3_rvalid", axi.rvalid, 0);
    axi.rready = 0;
    axi_read(32'h07, 0, rd, rs);
    check("r_unaligned", rd, 32'hDEADBEEF);

    // Byte strobes.
    axi_write(32'h10, 32'h11223344, 4'hF, 0, rs);
    axi_write(32'h10, 32'hAABBCCDD, 4'b0101, 1, rs);
    check("strb_bresp", rs, 0);
    axi_read(32'h10, 0, rd, rs);
    check("strb_rdata", rd, 32'h11BB33DD);

    // W before AW, then B stall with a second write queued behind it.
    axi.wdata = 32'hA1A1A1A1; axi.wstrb = 4'hF; axi.wvalid = 1; axi.awaddr = 32'h20;
    tick();
    axi.wvalid = 0;
    check("wfirst_wready", axi.wready, 0);
    check("wfirst_awready", axi.awready, 1);
    axi.awvalid = 1;
    tick();
    axi.awvalid = 0;
    check("wfirst_n1_bvalid", axi.bvalid, 0);
    tick();
    check("stall_bvalid0", axi.bvalid, 1);
    axi.awaddr = 32'h24; axi.wdata = 32'hA2A2A2A2; axi.awvalid = 1; axi.wvalid = 1;
    check("stall_awready_open", axi.awready, 1);
    tick();
    axi.awvalid = 0; axi.wvalid = 0;
    for (int i = 0; i < 3; i++) begin
      check("stall_bvalid", axi.bvalid, 1);
      check("stall_bresp", axi.bresp, 0);
      check("stall_awready", axi.awready, 0);
      check("stall_wready", axi.wready, 0);
      tick();
    end
    axi.bready = 1;
    nb = 0;
    for (int i = 0; i < 4; i++) begin
      if (axi.bvalid && axi.bready) nb++;
      tick();
    end
    axi.bready = 0;
    check("stall_b_count", nb, 2);
    check("stall_awready_after", axi.awready, 1);

    // Read stall with a second AR queued.
    axi.araddr = 32'h20; axi.arvalid = 1; axi.rready = 0;
    tick();
    axi.araddr = 32'h24;
    tick();
    check("rstall_rdata0", axi.rdata, 32'hA1A1A1A1);
    check("rstall_arready_open", axi.arready, 1);
    tick();
    axi.arvalid = 0;
    for (int i = 0; i < 3; i++) begin
      check("rstall_rvalid", axi.rvalid, 1);
      check("rstall_rdata", axi.rdata, 32'hA1A1A1A1);
      check("rstall_arready", axi.arready, 0);
      tick();
    end
    axi.rready = 1;
    tick();
    check("rstall_2nd_rvalid", axi.rvalid, 1);
    check("rstall_2nd_rdata", axi.rdata, 32'hA2A2A2A2);
    tick();
    check("rstall_done_rvalid", axi.rvalid, 0);
    axi.rready = 0;

    // Read and write commit to the same word in one cycle.
    axi_write(32'h30, 32'h55555555, 4'hF, 0, rs);
    axi.awaddr = 32'h30; axi.wdata = 32'hAAAAAAAA; axi.wstrb = 4'hF;
    axi.awvalid = 1; axi.wvalid = 1; axi.araddr = 32'h30; axi.arvalid = 1;
    axi.bready = 1; axi.rready = 1;
    tick();
    axi.awvalid = 0; axi.wvalid = 0; axi.arvalid = 0;
    tick();
    check("rbw_bvalid", axi.bvalid, 1);
    check("rbw_rvalid", axi.rvalid, 1);
    check("rbw_old_data", axi.rdata, 32'h55555555);
    tick();
    axi.bready = 0; axi.rready = 0;
    axi_read(32'h30, 0, rd, rs);
    check("rbw_new_data", rd, 32'hAAAAAAAA);

    // Aliasing / out-of-range.
    axi_write(32'h00, 32'hCAFEF00D, 4'hF, 0, rs);
    axi_write(32'h80, 32'h12345678, 4'hF, 0, rs);
`ifdef AXI4L_DPRAM_SLVERR_EN
    check("oor_bresp", rs, 2);
    axi_read(32'h00, 0, rd, rs);
    check("oor_word0", rd, 32'hCAFEF00D);
    axi_read(32'h80, 0, rd, rs);
    check("oor_rdata", rd, 0);
    check("oor_rresp", rs, 2);
`else
    check("alias_bresp", rs, 0);
    axi_read(32'h00, 0, rd, rs);
    check("alias_rdata", rd, 32'h12345678);
    check("alias_rresp", rs, 0);
    axi_read(32'h84, 0, rd, rs);
    check("alias_rdata_84", rd, 32'hDEADBEEF);
`endif

    // Back-to-back traffic with random gaps.
    for (int k = 0; k < 5; k++) begin
      repeat ($urandom_range(0, 2)) tick();
      axi_write(32'h40 + 4 * k, 32'h10000000 + k, 4'hF, $urandom_range(0, 2), rs);
      check("b2b_bresp", rs, 0);
    end
    for (int k = 0; k < 5; k++) begin
      repeat ($urandom_range(0, 2)) tick();
      axi_read(32'h40 + 4 * k, $urandom_range(0, 2), rd, rs);
      check("b2b_rdata", rd, 32'h10000000 + k);
    end

    // Reset after handshakes but before commit/read.
    axi.awaddr = 32'h44; axi.wdata = 32'hBAD0BAD0; axi.wstrb = 4'hF;
    axi.awvalid = 1; axi.wvalid = 1; axi.araddr = 32'h40; axi.arvalid = 1;
    axi.bready = 1; axi.rready = 1;
    tick();
    axi.awvalid = 0; axi.wvalid = 0; axi.arvalid = 0;
    aresetn = 0;
    tick();
    aresetn = 1;
    check("mrst_bvalid", axi.bvalid, 0);
    check("mrst_rvalid", axi.rvalid, 0);
    check("mrst_awready", axi.awready, 1);
    check("mrst_arready", axi.arready, 1);
    nr = 0;
    for (int i = 0; i < 5; i++) begin
      if (axi.bvalid || axi.rvalid) nr++;
      tick();
    end
    check("mrst_no_resp", nr, 0);
    axi.bready = 0; axi.rready = 0;
    axi_read(32'h44, 0, rd, rs);
    check("mrst_ram_kept", rd, 32'h10000001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
